serial_sub: RTL and testbench

// - Bit-serial subtractor: diff = a - b - bin. One bit per clock, LSB first.
// - Inverse of the ripple-carry adder datapath: one borrow flip-flop

---
 rtl/serial_sub.sv | 87 ++++++++
 tb/tb_serial_sub.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_sub.sv
// Bit-serial subtractor: diff = a - b - bin, one bit per clock, LSB first.
// Latency: WIDTH+1 cycles from accepted start to the done pulse; start is ignored while busy.
module serial_sub #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] res;
    logic             br;
    logic [CW-1:0]    cnt;

    logic             ai;
    logic             bi;
    logic             d;
    logic             br_nxt;
    logic [WIDTH-1:0] res_nxt;

    assign ai      = sa[0];
    assign bi      = sb[0];
    assign d       = ai ^ bi ^ br;
    assign br_nxt  = (~ai & bi) | (~(ai ^ bi) & br);
    // new bit enters at the MSB so that after WIDTH shifts bit 0 sits at res[0]
    assign res_nxt = (res >> 1) | (WIDTH'(d) << (WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            sa    <= '0;
            sb    <= '0;
            res   <= '0;
            br    <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            diff  <= '0;
            bout  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        state <= RUN;
                        busy  <= 1'b1;
                        sa    <= a;
                        sb    <= b;
                        br    <= bin;
                        cnt   <= '0;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    sa  <= sa >> 1;
                    sb  <= sb >> 1;
                    br  <= br_nxt;
                    res <= res_nxt;
                    cnt <= cnt + 1'b1;
                    // results are published only here so they stay stable during RUN
                    if (cnt == CW'(WIDTH - 1)) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        diff  <= res_nxt;
                        bout  <= br_nxt;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_sub.sv
// Self-checking bench for serial_sub: directed WIDTH=3 vectors and corner sequences,
// plus random WIDTH=8 operations checked against a plain arithmetic model.
module tb_serial_sub;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       start3, bin3, busy3, done3, bout3;
    logic [2:0] a3, b3, diff3;
    logic       start8, bin8, busy8, done8, bout8;
    logic [7:0] a8, b8, diff8;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_sub #(.WIDTH(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .a(a3), .b(b3), .bin(bin3),
        .busy(busy3), .done(done3), .diff(diff3), .bout(bout3)
    );

    serial_sub #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .bin(bin8),
        .busy(busy8), .done(done8), .diff(diff8), .bout(bout8)
    );

    typedef struct {
        logic [2:0] a;
        logic [2:0] b;
        logic       bin;
        logic [2:0] d;
        logic       bo;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic op3(input logic [2:0] ta, input logic [2:0] tb_, input logic tbin,
                       input logic [2:0] ed, input logic eb, input string nm);
        int         nb;
        bit         seen;
        logic [2:0] pd;
        @(negedge clk);
        a3 = ta; b3 = tb_; bin3 = tbin; start3 = 1'b1;
        pd = diff3;
        @(negedge clk);
        start3 = 1'b0;
        a3 = 3'($urandom); b3 = 3'($urandom); bin3 = 1'($urandom);
        nb = 0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (done3) begin
                seen = 1'b1;
            end else begin
                if (busy3) nb++;
                chk({nm, " diff held"}, diff3, pd);
                @(negedge clk);
            end
        end
        chk({nm, " done seen"}, seen, 1);
        chk({nm, " busy cycles"}, nb, 3);
        chk({nm, " diff"}, diff3, ed);
        chk({nm, " bout"}, bout3, eb);
        chk({nm, " busy&done"}, busy3, 0);
        @(negedge clk);
        chk({nm, " done pulse"}, done3, 0);
    endtask

    task automatic op8(input logic [7:0] ta, input logic [7:0] tb_, input logic tbin);
        logic [8:0] ref9;
        bit         seen;
        // reference: {bout,diff} = {0,a} - b - bin in 9-bit arithmetic
        ref9 = {1'b0, ta} - {1'b0, tb_} - {8'd0, tbin};
        @(negedge clk);
        a8 = ta; b8 = tb_; bin8 = tbin; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (done8) seen = 1'b1;
            else @(negedge clk);
        end
        if (!seen) chk("rnd timeout", 0, 1);
        else begin
            chk("rnd diff", diff8, ref9[7:0]);
            chk("rnd bout", bout8, ref9[8]);
        end
    endtask

    initial begin
        int t1, t2, k;
        bit seen;

        tbl[0] = '{3'd5, 3'd3, 1'b0, 3'b010, 1'b0};
        tbl[1] = '{3'd3, 3'd5, 1'b0, 3'b110, 1'b1};
        tbl[2] = '{3'd0, 3'd0, 1'b1, 3'b111, 1'b1};
        tbl[3] = '{3'd7, 3'd7, 1'b0, 3'd0,   1'b0};
        tbl[4] = '{3'd6, 3'd1, 1'b0, 3'd5,   1'b0};
        tbl[5] = '{3'd0, 3'd7, 1'b1, 3'd0,   1'b1};
        tbl[6] = '{3'd7, 3'd0, 1'b0, 3'd7,   1'b0};

        rst_n = 1'b0;
        start3 = 1'b0; a3 = '0; b3 = '0; bin3 = 1'b0;
        start8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
        #12;
        chk("reset busy", busy3, 0);
        chk("reset done", done3, 0);
        chk("reset diff", diff3, 0);
        chk("reset bout", bout3, 0);
        chk("reset out8", {busy8, done8, diff8, bout8}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++)
            op3(tbl[i].a, tbl[i].b, tbl[i].bin, tbl[i].d, tbl[i].bo, $sformatf("vec%0d", i));

        // back-to-back with start held high
        @(negedge clk);
        a3 = 3'd7; b3 = 3'd7; bin3 = 1'b0; start3 = 1'b1;
        @(negedge clk);
        a3 = 3'd6; b3 = 3'd1;
        t1 = -1; t2 = -1;
        for (int i = 0; i < 30 && t2 < 0; i++) begin
            if (t1 >= 0 && !done3) start3 = 1'b0;
            if (done3) begin
                if (t1 < 0) begin
                    t1 = cyc;
                    chk("b2b first diff", diff3, 0);
                    chk("b2b first bout", bout3, 0);
                end else begin
                    t2 = cyc;
                    chk("b2b second diff", diff3, 5);
                    chk("b2b second bout", bout3, 0);
                end
            end
            @(negedge clk);
        end
        start3 = 1'b0;
        chk("b2b timeout", (t2 >= 0), 1);
        chk("b2b spacing", t2 - t1, 4);
        @(negedge clk);

        // start pulsed mid-RUN must be ignored
        @(negedge clk);
        a3 = 3'd5; b3 = 3'd3; bin3 = 1'b0; start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        @(negedge clk);
        a3 = 3'd0; b3 = 3'd7; start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        k = 0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (done3) seen = 1'b1;
            else begin k++; @(negedge clk); end
        end
        chk("midrun done latency", k, 1);
        chk("midrun diff", diff3, 2);
        chk("midrun bout", bout3, 0);
        @(negedge clk);
        chk("midrun no restart", busy3, 0);

        // asynchronous reset during RUN cycle 2
        @(negedge clk);
        a3 = 3'd3; b3 = 3'd5; bin3 = 1'b0; start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst busy", busy3, 0);
        chk("rst done", done3, 0);
        chk("rst diff", diff3, 0);
        chk("rst bout", bout3, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (done3 || busy3) seen = 1'b1;
            @(negedge clk);
        end
        chk("rst no done", seen, 0);
        op3(3'd6, 3'd1, 1'b0, 3'd5, 1'b0, "post-reset");

        for (int i = 0; i < 1000; i++)
            op8(8'($urandom), 8'($urandom), 1'($urandom));
        op8(8'd0, 8'hff, 1'b1);
        op8(8'hff, 8'hff, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
